dram_axi_write_master: RTL and testbench
========================================

Name: dram_axi_write_master

Overview:
- AXI4 write master that consumes the DRAM write command/data stream produced by the camera-link gearbox stage.
- Inputs: 1-cycle command pulse (address, burst length) plus 512-bit beat data taken from a first-word-fall-through (FWFT) FIFO.
- Issues one INCR burst per command on the DRAM AXI port and reports busy back to the command source.
- Sits in the m_axi_aclk domain, between the gearbox async FIFO read side and the PS DDR AXI slave port.

Parameters:
- DRAM_ADDR_WIDTH, 39, byte address width of command and AXI address.
- DRAM_DATA_WIDTH, 512, data beat width; AWSIZE = log2(DRAM_DATA_WIDTH/8).

Ports:
- m_axi_aclk  in  1  single clock.
- reset  in  1  synchronous, active-high.
- dram_write_en  in  1  command pulse; also means beat 0 is on dram_write_data and the source has popped it.
- dram_write_addr  in  DRAM_ADDR_WIDTH  burst start byte address.
- dram_write_len  in  8  AXI AWLEN (beats-1).
- dram_write_data  in  DRAM_DATA_WIDTH  FWFT FIFO head data.
- dram_data_valid  in  1  FIFO not empty.
- dram_data_pop  out  1  pop pulse for beats 1..len.
- dram_write_busy  out  1  command in flight.
- m_axi_awaddr/awlen/awsize/awburst/awcache/awprot/awvalid  out  39/8/3/2/4/3/1  AW channel.
- m_axi_awready  in  1.
- m_axi_wdata/wstrb/wlast/wvalid  out  512/64/1/1  W channel.
- m_axi_wready  in  1.
- m_axi_bresp  in  2.
- m_axi_bvalid  in  1.
- m_axi_bready  out  1.
- resp_err  out  1  sticky, BRESP != OKAY seen.
- cmd_drop  out  1  sticky, command arrived while busy.

Behaviour:
- Reset values: all valids/ready/pop/busy/flags = 0; awaddr, wdata = 0; state IDLE; beat counter 0.
- Constant AXI fields: awsize = 3'd6, awburst = INCR (2'b01), awcache = 4'b0011, awprot = 0, wstrb = all ones.
- IDLE: on dram_write_en, register addr, len and data (beat 0); go to ADDR. busy=1 from the next cycle.
- ADDR: awvalid=1, held stable until awready. On handshake: awvalid=0, wvalid=1 next cycle, go to DATA. W is never issued before the AW handshake.
- DATA: beat counter counts 0..len; wlast=1 when counter==len.
  - On W handshake with counter<len:
    - If dram_data_valid: load dram_write_data into wdata, pulse dram_data_pop for 1 cycle, keep wvalid=1.
    - Else: drop wvalid, wait in DATA. When valid rises, load + pop, then raise wvalid next cycle.
  - On the wlast handshake: wvalid=0, go to RESP.
- RESP: bready=1 until bvalid. On handshake:
  - If bresp != 2'b00, set resp_err.
  - Go to IDLE; busy=0 the following cycle.
- Minimum latency with slave always ready, len=0:
  - en at T0, AW handshake T1, W handshake T2, B earliest T3, busy low T4.
- Simultaneous events:
  - dram_write_en in any state other than IDLE is ignored and sets cmd_drop; no AXI effect.
  - en in the same cycle the RESP handshake completes is also dropped (state is still RESP).
- dram_data_pop is never asserted for beat 0 and never after wlast; total pops per command = len.
- Address is passed through unmodified. The source guarantees 64-byte alignment and no 4KB crossing; no splitting is done.
- Reset mid-burst returns to IDLE immediately with all valids low and sticky flags cleared. The system resets the AXI slave together with this block.
- Width rule: beat counter is 8 bits; len=255 gives 256 beats with no wrap.

Optional Feature:
- Macro: DRAM_WRITE_STATS_EN.
- Defined: adds stat_bursts (32-bit, +1 per B handshake) and stat_beats (32-bit, +1 per W handshake) output ports. Both are reset to 0 and wrap on overflow.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- len=0, addr=39'h400000000, data=512'hA5.., all slave readies high:
  - awaddr=39'h400000000, awlen=0 at T1; wdata=A5.., wlast=1 at T2; bresp=0 at T3.
  - busy high T1..T3, low T4; pops=0.
- len=3, FIFO holds 3 words, awready delayed 5 cycles:
  - awvalid held 5 cycles with awaddr stable; 4 W beats in order.
  - wlast only on beat 4; exactly 3 pop pulses.
- len=2, FIFO empty after beat 0 for 4 cycles:
  - wvalid drops after beat 0; resumes 1 cycle after valid rises with a pop.
  - Beat order preserved.
- wready toggling 1/0 each cycle, len=7:
  - wdata/wlast stable while wvalid && !wready; 8 beats, 7 pops.
- bresp=2'b10 on a burst: resp_err=1 and stays set; next command still runs normally.
  - Second dram_write_en while busy: cmd_drop=1, no extra AW.
- reset asserted during DATA beat 2 of len=5:
  - Next cycle: all valids 0, busy=0, flags 0.
  - A new command after reset completes normally.

Source files
------------

// File: rtl/dram_axi_write_master.sv
// AXI4 write master: one INCR burst per DRAM write command, beats 1..len pulled from an FWFT FIFO.
// Define DRAM_WRITE_STATS_EN to add the stat_bursts / stat_beats counters.
module dram_axi_write_master #(
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int DRAM_DATA_WIDTH = 512
) (
  input  logic                         m_axi_aclk,
  input  logic                         reset,
  input  logic                         dram_write_en,
  input  logic [DRAM_ADDR_WIDTH-1:0]   dram_write_addr,
  input  logic [7:0]                   dram_write_len,
  input  logic [DRAM_DATA_WIDTH-1:0]   dram_write_data,
  input  logic                         dram_data_valid,
  output logic                         dram_data_pop,
  output logic                         dram_write_busy,
  output logic [DRAM_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                   m_axi_awlen,
  output logic [2:0]                   m_axi_awsize,
  output logic [1:0]                   m_axi_awburst,
  output logic [3:0]                   m_axi_awcache,
  output logic [2:0]                   m_axi_awprot,
  output logic                         m_axi_awvalid,
  input  logic                         m_axi_awready,
  output logic [DRAM_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DRAM_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                         m_axi_wlast,
  output logic                         m_axi_wvalid,
  input  logic                         m_axi_wready,
  input  logic [1:0]                   m_axi_bresp,
  input  logic                         m_axi_bvalid,
  output logic                         m_axi_bready,
  output logic                         resp_err,
  output logic                         cmd_drop
`ifdef DRAM_WRITE_STATS_EN
  ,
  output logic [31:0]                  stat_bursts,
  output logic [31:0]                  stat_beats
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  state_t                       state_r, state_nx_s;
  logic [DRAM_ADDR_WIDTH-1:0]   awaddr_r, awaddr_nx_s;
  logic [7:0]                   len_r, len_nx_s;
  logic [7:0]                   cnt_r, cnt_nx_s;
  logic [DRAM_DATA_WIDTH-1:0]   wdata_r, wdata_nx_s;
  logic                         awvalid_r, awvalid_nx_s;
  logic                         wvalid_r, wvalid_nx_s;
  logic                         wlast_r, wlast_nx_s;
  logic                         bready_r, bready_nx_s;
  logic                         busy_r, busy_nx_s;
  logic                         resp_err_r, resp_err_nx_s;
  logic                         cmd_drop_r, cmd_drop_nx_s;
  logic                         pop_s;
  logic                         aw_hs_s, w_hs_s, b_hs_s;

  assign aw_hs_s = awvalid_r & m_axi_awready;
  assign w_hs_s  = wvalid_r & m_axi_wready;
  assign b_hs_s  = bready_r & m_axi_bvalid;

  // Next-state and next-output computation for the burst FSM
  always_comb begin
    state_nx_s    = state_r;
    awaddr_nx_s   = awaddr_r;
    len_nx_s      = len_r;
    cnt_nx_s      = cnt_r;
    wdata_nx_s    = wdata_r;
    awvalid_nx_s  = awvalid_r;
    wvalid_nx_s   = wvalid_r;
    wlast_nx_s    = wlast_r;
    bready_nx_s   = bready_r;
    busy_nx_s     = busy_r;
    resp_err_nx_s = resp_err_r;
    cmd_drop_nx_s = cmd_drop_r;
    pop_s         = 1'b0;
    if (dram_write_en && (state_r != ST_IDLE)) begin
      cmd_drop_nx_s = 1'b1;
    end else begin
      cmd_drop_nx_s = cmd_drop_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (dram_write_en) begin
          awaddr_nx_s  = dram_write_addr;
          len_nx_s     = dram_write_len;
          wdata_nx_s   = dram_write_data;
          cnt_nx_s     = 8'd0;
          wlast_nx_s   = (dram_write_len == 8'd0);
          awvalid_nx_s = 1'b1;
          busy_nx_s    = 1'b1;
          state_nx_s   = ST_ADDR;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (aw_hs_s) begin
          awvalid_nx_s = 1'b0;
          wvalid_nx_s  = 1'b1;
          state_nx_s   = ST_DATA;
        end else begin
          state_nx_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (w_hs_s && (cnt_r == len_r)) begin
          wvalid_nx_s = 1'b0;
          wlast_nx_s  = 1'b0;
          bready_nx_s = 1'b1;
          state_nx_s  = ST_RESP;
        end else if (w_hs_s) begin
          cnt_nx_s   = cnt_r + 8'd1;
          wlast_nx_s = ((cnt_r + 8'd1) == len_r);
          if (dram_data_valid) begin
            wdata_nx_s = dram_write_data;
            pop_s      = 1'b1;
            state_nx_s = ST_DATA;
          end else begin
            wvalid_nx_s = 1'b0;
            state_nx_s  = ST_WAIT;
          end
        end else begin
          state_nx_s = ST_DATA;
        end
      end
      ST_WAIT: begin
        // Beat counter already points at the missing beat; capture it as soon as it shows up
        if (dram_data_valid) begin
          wdata_nx_s  = dram_write_data;
          pop_s       = 1'b1;
          wvalid_nx_s = 1'b1;
          state_nx_s  = ST_DATA;
        end else begin
          state_nx_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (b_hs_s) begin
          bready_nx_s = 1'b0;
          busy_nx_s   = 1'b0;
          state_nx_s  = ST_IDLE;
          if (m_axi_bresp != 2'b00) begin
            resp_err_nx_s = 1'b1;
          end else begin
            resp_err_nx_s = resp_err_r;
          end
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: begin
        awvalid_nx_s = 1'b0;
        wvalid_nx_s  = 1'b0;
        bready_nx_s  = 1'b0;
        busy_nx_s    = 1'b0;
        state_nx_s   = ST_IDLE;
      end
    endcase
  end

  // The FWFT head is consumed in the same cycle it is captured, so the pop stays combinational
  assign dram_data_pop = pop_s & ~reset;

  // State and output registers
  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      awaddr_r   <= '0;
      len_r      <= 8'd0;
      cnt_r      <= 8'd0;
      wdata_r    <= '0;
      awvalid_r  <= 1'b0;
      wvalid_r   <= 1'b0;
      wlast_r    <= 1'b0;
      bready_r   <= 1'b0;
      busy_r     <= 1'b0;
      resp_err_r <= 1'b0;
      cmd_drop_r <= 1'b0;
    end else begin
      state_r    <= state_nx_s;
      awaddr_r   <= awaddr_nx_s;
      len_r      <= len_nx_s;
      cnt_r      <= cnt_nx_s;
      wdata_r    <= wdata_nx_s;
      awvalid_r  <= awvalid_nx_s;
      wvalid_r   <= wvalid_nx_s;
      wlast_r    <= wlast_nx_s;
      bready_r   <= bready_nx_s;
      busy_r     <= busy_nx_s;
      resp_err_r <= resp_err_nx_s;
      cmd_drop_r <= cmd_drop_nx_s;
    end
  end

  assign m_axi_awaddr    = awaddr_r;
  assign m_axi_awlen     = len_r;
  assign m_axi_awsize    = 3'($clog2(DRAM_DATA_WIDTH / 8));
  assign m_axi_awburst   = 2'b01;
  assign m_axi_awcache   = 4'b0011;
  assign m_axi_awprot    = 3'b000;
  assign m_axi_awvalid   = awvalid_r;
  assign m_axi_wdata     = wdata_r;
  assign m_axi_wstrb     = {(DRAM_DATA_WIDTH/8){1'b1}};
  assign m_axi_wlast     = wlast_r;
  assign m_axi_wvalid    = wvalid_r;
  assign m_axi_bready    = bready_r;
  assign dram_write_busy = busy_r;
  assign resp_err        = resp_err_r;
  assign cmd_drop        = cmd_drop_r;

`ifdef DRAM_WRITE_STATS_EN
  logic [31:0] stat_bursts_r;
  logic [31:0] stat_beats_r;

  // Free-running burst and beat counters, wrapping on overflow
  always_ff @(posedge m_axi_aclk) begin
    if (reset) begin
      stat_bursts_r <= 32'd0;
      stat_beats_r  <= 32'd0;
    end else begin
      if (b_hs_s) stat_bursts_r <= stat_bursts_r + 32'd1;
      if (w_hs_s) stat_beats_r  <= stat_beats_r + 32'd1;
    end
  end

  assign stat_bursts = stat_bursts_r;
  assign stat_beats  = stat_beats_r;
`endif

endmodule

// File: tb/tb_dram_axi_write_master.sv
// Scoreboard bench for dram_axi_write_master: stimulus queues expected AW/W traffic and a FIFO
// image, a monitor sampling just before each rising edge compares handshakes, pops and flags.
module tb_dram_axi_write_master;
  localparam int AW = 39;
  localparam int DW = 512;

  logic              m_axi_aclk = 1'b0;
  logic              reset = 1'b1;
  logic              dram_write_en = 1'b0;
  logic [AW-1:0]     dram_write_addr = '0;
  logic [7:0]        dram_write_len = 8'd0;
  logic [DW-1:0]     dram_write_data = '0;
  logic              dram_data_valid = 1'b0;
  logic              dram_data_pop;
  logic              dram_write_busy;
  logic [AW-1:0]     m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic [3:0]        m_axi_awcache;
  logic [2:0]        m_axi_awprot;
  logic              m_axi_awvalid;
  logic              m_axi_awready = 1'b0;
  logic [DW-1:0]     m_axi_wdata;
  logic [DW/8-1:0]   m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_wvalid;
  logic              m_axi_wready = 1'b0;
  logic [1:0]        m_axi_bresp = 2'b00;
  logic              m_axi_bvalid = 1'b0;
  logic              m_axi_bready;
  logic              resp_err;
  logic              cmd_drop;
`ifdef DRAM_WRITE_STATS_EN
  logic [31:0]       stat_bursts;
  logic [31:0]       stat_beats;
`endif

  dram_axi_write_master #(.DRAM_ADDR_WIDTH(AW), .DRAM_DATA_WIDTH(DW)) dut (
    .m_axi_aclk(m_axi_aclk), .reset(reset),
    .dram_write_en(dram_write_en), .dram_write_addr(dram_write_addr),
    .dram_write_len(dram_write_len), .dram_write_data(dram_write_data),
    .dram_data_valid(dram_data_valid), .dram_data_pop(dram_data_pop),
    .dram_write_busy(dram_write_busy),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot),
    .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .resp_err(resp_err), .cmd_drop(cmd_drop)
`ifdef DRAM_WRITE_STATS_EN
    , .stat_bursts(stat_bursts), .stat_beats(stat_beats)
`endif
  );

  always #5 m_axi_aclk = ~m_axi_aclk;

  typedef struct { logic [AW-1:0] addr; logic [7:0] len; } aw_exp_t;
  typedef struct { logic [DW-1:0] data; logic last; } w_exp_t;

  aw_exp_t       exp_aw_q[$];
  w_exp_t        exp_w_q[$];
  logic [DW-1:0] fifo_q[$];

  int tests = 0;
  int fails = 0;

  // model / shared state
  logic          outstanding = 1'b0;
  logic          acc_flag = 1'b0;
  logic          drop_flag = 1'b0;
  logic [DW-1:0] beat0_drv = '0;
  int            cur_len = 0;
  int            aw_delay = 0;
  int            wready_mode = 0;
  logic [1:0]    bresp_cfg = 2'b00;
  int            fifo_gap = 0;
  logic          lat_check = 1'b0;
  int            aw_wait_cnt = 0;
  logic          b_pending = 1'b0;
  logic          wr_toggle = 1'b1;
  int            beats_burst = 0;
  int            pops_burst = 0;
  int            bursts_total = 0;
  int            beats_total = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return {7'($urandom), 26'($urandom), 6'd0};
  endfunction

  // slave and FIFO drivers, updated just after each falling edge
  initial begin
    forever begin
      @(negedge m_axi_aclk); #1;
      m_axi_awready = (aw_wait_cnt >= aw_delay);
      if (wready_mode == 0) m_axi_wready = 1'b1;
      else if (wready_mode == 1) m_axi_wready = wr_toggle;
      else m_axi_wready = 1'($urandom_range(1, 0));
      m_axi_bvalid = b_pending;
      m_axi_bresp = b_pending ? bresp_cfg : 2'b00;
      dram_data_valid = (fifo_q.size() != 0) && (fifo_gap == 0);
      if (acc_flag) dram_write_data = beat0_drv;
      else if (fifo_q.size() != 0) dram_write_data = fifo_q[0];
      else dram_write_data = '0;
    end
  end

  // monitor: samples 2 ns before the rising edge and checks against the model
  initial begin
    int cyc = 0, en_cyc = 0, aw_cyc = 0, wl_cyc = 0;
    logic busy_exp = 1'b0, rerr_exp = 1'b0, cdrop_exp = 1'b0;
    logic busy_n, rerr_n, cdrop_n;
    logic aw_done = 1'b0, aw_hold = 1'b0, w_hold = 1'b0, post_reset = 1'b0;
    logic [AW-1:0] hold_addr = '0;
    logic [7:0] hold_len = 8'd0;
    logic [DW-1:0] hold_data = '0;
    logic hold_last = 1'b0;
    aw_exp_t ea;
    w_exp_t ew;
    forever begin
      @(negedge m_axi_aclk); #3;
      cyc++;
      if (reset) begin
        exp_aw_q.delete(); exp_w_q.delete(); fifo_q.delete();
        outstanding = 1'b0; busy_exp = 1'b0; rerr_exp = 1'b0; cdrop_exp = 1'b0;
        b_pending = 1'b0; aw_wait_cnt = 0; aw_done = 1'b0; aw_hold = 1'b0; w_hold = 1'b0;
        beats_burst = 0; pops_burst = 0; bursts_total = 0; beats_total = 0;
        fifo_gap = 0; post_reset = 1'b1;
      end else begin
        busy_n = busy_exp; rerr_n = rerr_exp; cdrop_n = cdrop_exp;
        chk("busy", DW'(dram_write_busy), DW'(busy_exp));
        chk("resp_err", DW'(resp_err), DW'(rerr_exp));
        chk("cmd_drop", DW'(cmd_drop), DW'(cdrop_exp));
        if (post_reset) begin
          chk("rst_awvalid", DW'(m_axi_awvalid), DW'(1'b0));
          chk("rst_wvalid", DW'(m_axi_wvalid), DW'(1'b0));
          chk("rst_bready", DW'(m_axi_bready), DW'(1'b0));
          chk("rst_pop", DW'(dram_data_pop), DW'(1'b0));
          chk("rst_awaddr", DW'(m_axi_awaddr), DW'(0));
          chk("rst_wdata", m_axi_wdata, '0);
          post_reset = 1'b0;
        end
        if (m_axi_awvalid) begin
          if (aw_hold) begin
            chk("aw_stable_addr", DW'(m_axi_awaddr), DW'(hold_addr));
            chk("aw_stable_len", DW'(m_axi_awlen), DW'(hold_len));
          end
          if (m_axi_awready) begin
            chk("aw_expected", DW'(exp_aw_q.size() != 0), DW'(1'b1));
            if (exp_aw_q.size() != 0) begin
              ea = exp_aw_q.pop_front();
              chk("awaddr", DW'(m_axi_awaddr), DW'(ea.addr));
              chk("awlen", DW'(m_axi_awlen), DW'(ea.len));
            end
            chk("awsize", DW'(m_axi_awsize), DW'(3'd6));
            chk("awburst", DW'(m_axi_awburst), DW'(2'b01));
            chk("awcache", DW'(m_axi_awcache), DW'(4'b0011));
            chk("awprot", DW'(m_axi_awprot), DW'(3'b000));
            aw_done = 1'b1; aw_cyc = cyc; aw_wait_cnt = 0;
          end else begin
            aw_wait_cnt++;
          end
          aw_hold = !m_axi_awready; hold_addr = m_axi_awaddr; hold_len = m_axi_awlen;
        end else begin
          aw_hold = 1'b0;
        end
        if (m_axi_wvalid) begin
          chk("w_after_aw", DW'(aw_done), DW'(1'b1));
          if (w_hold) begin
            chk("w_stable_data", m_axi_wdata, hold_data);
            chk("w_stable_last", DW'(m_axi_wlast), DW'(hold_last));
          end
          if (m_axi_wready) begin
            chk("w_expected", DW'(exp_w_q.size() != 0), DW'(1'b1));
            if (exp_w_q.size() != 0) begin
              ew = exp_w_q.pop_front();
              chk("wdata", m_axi_wdata, ew.data);
              chk("wlast", DW'(m_axi_wlast), DW'(ew.last));
            end
            chk("wstrb", DW'(m_axi_wstrb), DW'({(DW/8){1'b1}}));
            beats_burst++; beats_total++;
            if (m_axi_wlast) begin
              b_pending = 1'b1; aw_done = 1'b0; wl_cyc = cyc;
            end
          end
          w_hold = !m_axi_wready; hold_data = m_axi_wdata; hold_last = m_axi_wlast;
        end else begin
          w_hold = 1'b0;
        end
        if (dram_data_pop) begin
          chk("pop_when_valid", DW'(dram_data_valid), DW'(1'b1));
          if (fifo_q.size() != 0) void'(fifo_q.pop_front());
          pops_burst++;
        end
        if (m_axi_bvalid && m_axi_bready) begin
          b_pending = 1'b0; outstanding = 1'b0; busy_n = 1'b0;
          if (bresp_cfg != 2'b00) rerr_n = 1'b1;
          chk("pops_per_cmd", DW'(pops_burst), DW'(cur_len));
          chk("beats_per_cmd", DW'(beats_burst), DW'(cur_len + 1));
          if (lat_check) begin
            chk("lat_aw", DW'(aw_cyc - en_cyc), DW'(1));
            chk("lat_wlast", DW'(wl_cyc - en_cyc), DW'(2));
            chk("lat_b", DW'(cyc - en_cyc), DW'(3));
          end
          pops_burst = 0; beats_burst = 0; bursts_total++;
        end
        if (acc_flag) begin
          busy_n = 1'b1; en_cyc = cyc;
        end
        if (drop_flag) cdrop_n = 1'b1;
        if (fifo_gap > 0) fifo_gap--;
        wr_toggle = !wr_toggle;
        busy_exp = busy_n; rerr_exp = rerr_n; cdrop_exp = cdrop_n;
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    while (outstanding && g < 3000) begin
      @(negedge m_axi_aclk);
      g++;
    end
    chk("idle_wait", DW'(outstanding), DW'(1'b0));
  endtask

  task automatic issue(input logic [AW-1:0] a, input int len, input logic [DW-1:0] b0,
                       input int awd, input int gap, input int wmode, input logic [1:0] br);
    logic [DW-1:0] d;
    wait_idle();
    aw_delay = awd; wready_mode = wmode; bresp_cfg = br; fifo_gap = gap;
    dram_write_en = 1'b1; dram_write_addr = a; dram_write_len = 8'(len);
    beat0_drv = b0; acc_flag = 1'b1;
    exp_aw_q.push_back('{addr: a, len: 8'(len)});
    exp_w_q.push_back('{data: b0, last: (len == 0)});
    for (int i = 1; i <= len; i++) begin
      d = rnd_data();
      fifo_q.push_back(d);
      exp_w_q.push_back('{data: d, last: (i == len)});
    end
    outstanding = 1'b1; cur_len = len;
    @(negedge m_axi_aclk);
    dram_write_en = 1'b0; acc_flag = 1'b0;
  endtask

  task automatic drop_en();
    dram_write_en = 1'b1; dram_write_addr = rnd_addr(); dram_write_len = 8'($urandom_range(7, 0));
    drop_flag = 1'b1;
    @(negedge m_axi_aclk);
    dram_write_en = 1'b0; drop_flag = 1'b0;
  endtask

  // stimulus
  initial begin
    int g;
    repeat (3) @(negedge m_axi_aclk);
    reset = 1'b0;
    @(negedge m_axi_aclk);
    lat_check = 1'b1;
    issue(39'h400000000, 0, {64{8'hA5}}, 0, 0, 0, 2'b00);
    wait_idle();
    lat_check = 1'b0;
    issue(rnd_addr(), 3, rnd_data(), 5, 0, 0, 2'b00);
    issue(rnd_addr(), 2, rnd_data(), 0, 6, 0, 2'b00);
    issue(rnd_addr(), 7, rnd_data(), 0, 0, 1, 2'b00);
    issue(rnd_addr(), 1, rnd_data(), 0, 0, 0, 2'b10);
    drop_en();
    issue(rnd_addr(), 2, rnd_data(), 0, 0, 0, 2'b00);
    issue(rnd_addr(), 5, rnd_data(), 0, 0, 0, 2'b00);
    g = 0;
    while (beats_burst != 2 && g < 200) begin
      @(negedge m_axi_aclk);
      g++;
    end
    chk("reach_beat2", DW'(beats_burst), DW'(2));
    reset = 1'b1;
    @(negedge m_axi_aclk);
    reset = 1'b0;
    @(negedge m_axi_aclk);
    issue(rnd_addr(), 4, rnd_data(), 0, 0, 0, 2'b00);
    issue(rnd_addr(), 255, rnd_data(), 0, 0, 0, 2'b00);
    for (int n = 0; n < 20; n++) begin
      issue(rnd_addr(), (n % 4 == 0) ? int'($urandom_range(40, 16)) : int'($urandom_range(6, 0)),
            rnd_data(), int'($urandom_range(3, 0)), int'($urandom_range(8, 0)),
            (n % 3 == 0) ? 0 : 2, ($urandom_range(4, 0) == 0) ? 2'b10 : 2'b00);
      repeat ($urandom_range(5, 0)) @(negedge m_axi_aclk);
      if (outstanding && ($urandom_range(2, 0) == 0)) drop_en();
    end
    wait_idle();
    repeat (4) @(negedge m_axi_aclk);
    chk("aw_q_drained", DW'(exp_aw_q.size()), DW'(0));
    chk("w_q_drained", DW'(exp_w_q.size()), DW'(0));
    chk("fifo_drained", DW'(fifo_q.size()), DW'(0));
`ifdef DRAM_WRITE_STATS_EN
    chk("stat_bursts", DW'(stat_bursts), DW'(bursts_total));
    chk("stat_beats", DW'(stat_beats), DW'(beats_total));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
